// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared states, opcode encodings and lane geometry for alu_sequencer
package alu_seq_pkg;
    localparam int LANES  = 16;
    localparam int LANE_W = 32;
    localparam logic OP_ADD = 1'b1;
    localparam logic OP_MUL = 1'b0;
    typedef enum logic [2:0] {IDLE, READ, EXEC, EXEC2, WB_LO, WB_HI} state_e;
endpackage

// File: rtl/alu_sequencer.sv
// alu_sequencer: runs one vector command through read, ALU, and two write-backs.
// Define ALU_OUT_REG_EN to insert EXEC2 and capture ALU results one cycle later.
module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter int N      = LANES * LANE_W,
    parameter int REG_AW = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_op,
    input  logic [REG_AW-1:0] cmd_src1,
    input  logic [REG_AW-1:0] cmd_src2,
    input  logic [REG_AW-1:0] cmd_dst_lo,
    input  logic [REG_AW-1:0] cmd_dst_hi,
    output logic [REG_AW-1:0] rf_raddr1,
    output logic [REG_AW-1:0] rf_raddr2,
    input  logic [N-1:0]      rf_rdata1,
    input  logic [N-1:0]      rf_rdata2,
    output logic              alu_opcode,
    output logic [N-1:0]      alu_in1,
    output logic [N-1:0]      alu_in2,
    input  logic [N-1:0]      alu_lo,
    input  logic [N-1:0]      alu_hi,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_waddr,
    output logic [N-1:0]      rf_wdata,
    output logic              busy,
    output logic              done
);
`ifdef ALU_OUT_REG_EN
    localparam state_e CAP = EXEC2;
`else
    localparam state_e CAP = EXEC;
`endif
    state_e            state_q, state_d;
    logic              op_q;
    logic [REG_AW-1:0] src1_q, src2_q, dst_lo_q, dst_hi_q;
    logic [N-1:0]      in1_q, in2_q, lo_q, hi_q;
    logic              accept;

    assign accept = cmd_valid && cmd_ready;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = accept ? READ : IDLE;
            READ:    state_d = EXEC;
`ifdef ALU_OUT_REG_EN
            EXEC:    state_d = EXEC2;
`else
            EXEC:    state_d = WB_LO;
`endif
            EXEC2:   state_d = WB_LO;
            WB_LO:   state_d = WB_HI;
            WB_HI:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign cmd_ready  = state_q == IDLE;
    assign busy       = state_q != IDLE;
    assign done       = state_q == WB_HI;
    assign rf_we      = state_q == WB_LO || state_q == WB_HI;
    assign rf_raddr1  = state_q == READ ? src1_q : '0;
    assign rf_raddr2  = state_q == READ ? src2_q : '0;
    assign alu_opcode = op_q;
    // Read data arrives during EXEC; pass it straight through, then hold the registered copy
    assign alu_in1    = state_q == EXEC ? rf_rdata1 : in1_q;
    assign alu_in2    = state_q == EXEC ? rf_rdata2 : in2_q;
    assign rf_waddr   = state_q == WB_LO ? dst_lo_q : state_q == WB_HI ? dst_hi_q : '0;
    assign rf_wdata   = state_q == WB_LO ? lo_q : state_q == WB_HI ? hi_q : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            op_q     <= 1'b0;
            src1_q   <= '0;
            src2_q   <= '0;
            dst_lo_q <= '0;
            dst_hi_q <= '0;
            in1_q    <= '0;
            in2_q    <= '0;
            lo_q     <= '0;
            hi_q     <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q     <= cmd_op;
                src1_q   <= cmd_src1;
                src2_q   <= cmd_src2;
                dst_lo_q <= cmd_dst_lo;
                dst_hi_q <= cmd_dst_hi;
            end
            if (state_q == EXEC) begin
                in1_q <= rf_rdata1;
                in2_q <= rf_rdata2;
            end
            if (state_q == CAP) begin
                lo_q <= alu_lo;
                hi_q <= alu_hi;
            end
        end
    end
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: scoreboard bench with register-file and ALU models around alu_sequencer.
// Honours ALU_OUT_REG_EN for the expected write-back cycles.
module tb_alu_sequencer;
    import alu_seq_pkg::*;
    localparam int N = 512;
`ifdef ALU_OUT_REG_EN
    localparam int EX = 1;
`else
    localparam int EX = 0;
`endif
    typedef struct {
        logic [2:0]   a;
        logic [N-1:0] d;
        logic         last;
        int           cyc;
    } wr_t;

    logic clk = 1'b0, rst = 1'b1;
    logic cmd_valid = 1'b0, cmd_ready, cmd_op = 1'b0;
    logic [2:0] cmd_src1 = '0, cmd_src2 = '0, cmd_dst_lo = '0, cmd_dst_hi = '0;
    logic [2:0] rf_raddr1, rf_raddr2, rf_waddr;
    logic [N-1:0] rf_rdata1, rf_rdata2, alu_in1, alu_in2, alu_lo, alu_hi, rf_wdata;
    logic alu_opcode, rf_we, busy, done;
    logic tb_we = 1'b0;
    logic [2:0] tb_waddr = '0;
    logic [N-1:0] tb_wdata = '0;
    logic [N-1:0] rf [8];
    int cyc = 0;
    int n_cmp = 0, n_fail = 0;
    wr_t exp_q[$];
    wr_t obs_q[$];

    always #5 clk = ~clk;

    alu_sequencer dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_src1(cmd_src1), .cmd_src2(cmd_src2), .cmd_dst_lo(cmd_dst_lo), .cmd_dst_hi(cmd_dst_hi),
        .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
        .alu_opcode(alu_opcode), .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_lo(alu_lo), .alu_hi(alu_hi),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .busy(busy), .done(done)
    );

    function automatic logic [2*N-1:0] alu_f(input logic op, input logic [N-1:0] a, input logic [N-1:0] b);
        logic [N-1:0] lo, hi;
        longint p;
        for (int l = 0; l < LANES; l++) begin
            p = op == OP_ADD ? longint'($signed(a[l*32+:32])) + longint'($signed(b[l*32+:32]))
                             : longint'($signed(a[l*32+:32])) * longint'($signed(b[l*32+:32]));
            lo[l*32+:32] = p[31:0];
            hi[l*32+:32] = p[63:32];
        end
        return {hi, lo};
    endfunction

    always_comb {alu_hi, alu_lo} = alu_f(alu_opcode, alu_in1, alu_in2);

    always @(posedge clk) begin
        cyc <= cyc + 1;
        rf_rdata1 <= rf[rf_raddr1];
        rf_rdata2 <= rf[rf_raddr2];
        if (rf_we) rf[rf_waddr] <= rf_wdata;
        else if (tb_we) rf[tb_waddr] <= tb_wdata;
    end

    always @(negedge clk) if (rf_we || done) obs_q.push_back('{rf_waddr, rf_wdata, done, cyc});

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic set_reg(input logic [2:0] a, input logic [31:0] lane);
        tb_we = 1'b1;
        tb_waddr = a;
        tb_wdata = {LANES{lane}};
        @(posedge clk); #1;
        tb_we = 1'b0;
    endtask

    task automatic issue(input logic op, input logic [2:0] s1, input logic [2:0] s2,
                         input logic [2:0] dl, input logic [2:0] dh, input bit keep, output int t);
        logic [2*N-1:0] r;
        cmd_op = op; cmd_src1 = s1; cmd_src2 = s2; cmd_dst_lo = dl; cmd_dst_hi = dh;
        cmd_valid = 1'b1;
        t = -1;
        for (int i = 0; i < 12 && t < 0; i++) begin
            @(negedge clk);
            if (cmd_ready) begin
                t = cyc;
                r = alu_f(op, rf[s1], rf[s2]);
                exp_q.push_back('{dl, r[N-1:0], 1'b0, t + 3 + EX});
                exp_q.push_back('{dh, r[2*N-1:N], 1'b1, t + 4 + EX});
            end
            @(posedge clk); #1;
        end
        if (!keep) cmd_valid = 1'b0;
        if (t < 0) begin
            n_cmp++; n_fail++;
            $display("FAIL accept_timeout cmd_ready never seen");
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp += 6;
        if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", cmd_ready); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        if (rf_we !== 1'b0) begin n_fail++; $display("FAIL reset_we got %b want 0", rf_we); end
        if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
        if (rf_waddr !== 3'd0 || rf_raddr1 !== 3'd0) begin n_fail++; $display("FAIL reset_addr got %0d/%0d want 0", rf_waddr, rf_raddr1); end
        if (alu_in1 !== '0 || rf_wdata !== '0 || alu_opcode !== 1'b0) begin n_fail++; $display("FAIL reset_data got nonzero want 0"); end
        @(posedge clk); #1;
        rst = 1'b0;
        obs_q.delete();
    endtask

    task automatic test_add;
        int t;
        wr_t e, o;
        set_reg(3'd1, 32'd5);
        set_reg(3'd2, 32'd7);
        issue(OP_ADD, 3'd1, 3'd2, 3'd3, 3'd4, 1'b0, t);
        for (int c = 0; c < 16 && obs_q.size() < exp_q.size(); c++) @(posedge clk);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); n_cmp++;
            if (obs_q.size() == 0) begin n_fail++; $display("FAIL add_wb missing write want a=%0d", e.a); end
            else begin
                o = obs_q.pop_front();
                if (o.a !== e.a || o.d !== e.d || o.last !== e.last || o.cyc != e.cyc) begin
                    n_fail++; $display("FAIL add_wb got a=%0d done=%b cyc=%0d d=%h want a=%0d done=%b cyc=%0d d=%h", o.a, o.last, o.cyc, o.d, e.a, e.last, e.cyc, e.d);
                end
            end
        end
        @(posedge clk); #1;
        n_cmp += 2;
        if (rf[3] !== {LANES{32'd12}}) begin n_fail++; $display("FAIL add_r3 got %h want lanes 12", rf[3][31:0]); end
        if (rf[4] !== '0) begin n_fail++; $display("FAIL add_r4 got %h want lanes 0", rf[4][31:0]); end
    endtask

    task automatic test_mul;
        int t;
        wr_t e, o;
        logic [31:0] want [6];
        want = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000001, 32'h3FFFFFFF, 32'h00000002, 32'h3FFFFFFF};
        set_reg(3'd1, 32'hFFFFFFFF);
        set_reg(3'd2, 32'd2);
        set_reg(3'd5, 32'h7FFFFFFF);
        for (int k = 0; k < 3; k++) begin
            if (k == 0) issue(OP_MUL, 3'd1, 3'd2, 3'd3, 3'd4, 1'b0, t);
            else if (k == 1) issue(OP_MUL, 3'd5, 3'd5, 3'd3, 3'd4, 1'b0, t);
            else issue(OP_ADD, 3'd3, 3'd3, 3'd3, 3'd7, 1'b0, t);
            for (int c = 0; c < 16 && obs_q.size() < exp_q.size(); c++) @(posedge clk);
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front(); n_cmp++;
                if (obs_q.size() == 0) begin n_fail++; $display("FAIL mul_wb missing write want a=%0d", e.a); end
                else begin
                    o = obs_q.pop_front();
                    if (o.a !== e.a || o.d !== e.d || o.last !== e.last || o.cyc != e.cyc) begin
                        n_fail++; $display("FAIL mul_wb got a=%0d done=%b cyc=%0d d=%h want a=%0d done=%b cyc=%0d d=%h", o.a, o.last, o.cyc, o.d, e.a, e.last, e.cyc, e.d);
                    end
                end
            end
            @(posedge clk); #1;
            n_cmp++;
            if (rf[3] !== {LANES{want[2*k]}}) begin n_fail++; $display("FAIL mul_lo%0d got %h want %h", k, rf[3][31:0], want[2*k]); end
            n_cmp++;
            if (k < 2 && rf[4] !== {LANES{want[2*k+1]}}) begin n_fail++; $display("FAIL mul_hi%0d got %h want %h", k, rf[4][31:0], want[2*k+1]); end
        end
    endtask

    task automatic test_back_to_back;
        int t1, t2;
        wr_t e, o;
        issue(OP_ADD, 3'd1, 3'd2, 3'd3, 3'd4, 1'b1, t1);
        cmd_op = OP_MUL; cmd_src1 = 3'd5; cmd_src2 = 3'd2; cmd_dst_lo = 3'd0; cmd_dst_hi = 3'd7;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            n_cmp++;
            if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_ready T+%0d got %b want 0", i, cmd_ready); end
            @(posedge clk); #1;
        end
        issue(OP_MUL, 3'd5, 3'd2, 3'd0, 3'd7, 1'b0, t2);
        n_cmp++;
        if (t2 != t1 + 5 + EX) begin n_fail++; $display("FAIL b2b_accept got T+%0d want T+%0d", t2 - t1, 5 + EX); end
        for (int c = 0; c < 16 && obs_q.size() < exp_q.size(); c++) @(posedge clk);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); n_cmp++;
            if (obs_q.size() == 0) begin n_fail++; $display("FAIL b2b_wb missing write want a=%0d", e.a); end
            else begin
                o = obs_q.pop_front();
                if (o.a !== e.a || o.d !== e.d || o.last !== e.last || o.cyc != e.cyc) begin
                    n_fail++; $display("FAIL b2b_wb got a=%0d done=%b cyc=%0d d=%h want a=%0d done=%b cyc=%0d d=%h", o.a, o.last, o.cyc, o.d, e.a, e.last, e.cyc, e.d);
                end
            end
        end
        @(posedge clk); #1;
        n_cmp++;
        if (rf[0] !== {LANES{32'hFFFFFFFE}}) begin n_fail++; $display("FAIL b2b_r0 got %h want fffffffe", rf[0][31:0]); end
    endtask

    task automatic test_same_dst;
        int t;
        wr_t e, o;
        set_reg(3'd1, 32'h7FFFFFFF);
        set_reg(3'd2, 32'd1);
        issue(OP_ADD, 3'd1, 3'd2, 3'd6, 3'd6, 1'b0, t);
        for (int c = 0; c < 16 && obs_q.size() < exp_q.size(); c++) @(posedge clk);
        for (int k = 0; exp_q.size() > 0; k++) begin
            e = exp_q.pop_front(); n_cmp++;
            if (obs_q.size() == 0) begin n_fail++; $display("FAIL same_dst_wb missing write want a=%0d", e.a); end
            else begin
                o = obs_q.pop_front();
                if (o.a !== 3'd6 || o.d !== {LANES{(k == 0) ? 32'h80000000 : 32'h0}} || o.last !== e.last || o.cyc != e.cyc) begin
                    n_fail++; $display("FAIL same_dst_wb%0d got a=%0d done=%b cyc=%0d lane=%h want a=6 done=%b cyc=%0d", k, o.a, o.last, o.cyc, o.d[31:0], e.last, e.cyc);
                end
            end
        end
        @(posedge clk); #1;
        n_cmp++;
        if (rf[6] !== '0) begin n_fail++; $display("FAIL same_dst_r6 got %h want 00000000", rf[6][31:0]); end
    endtask

    task automatic test_reset_abort;
        int t;
        wr_t e, o;
        set_reg(3'd1, 32'd5);
        set_reg(3'd2, 32'd7);
        set_reg(3'd0, 32'd99);
        issue(OP_ADD, 3'd1, 3'd2, 3'd0, 3'd0, 1'b0, t);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        repeat (8) @(posedge clk);
        @(negedge clk);
        n_cmp += 3;
        if (obs_q.size() != 0) begin n_fail++; $display("FAIL abort_writes got %0d want 0", obs_q.size()); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy got %b want 0", busy); end
        if (rf[0] !== {LANES{32'd99}}) begin n_fail++; $display("FAIL abort_r0 got %h want 00000063", rf[0][31:0]); end
        obs_q.delete();
        @(posedge clk); #1;
        issue(OP_ADD, 3'd1, 3'd2, 3'd0, 3'd5, 1'b0, t);
        for (int c = 0; c < 16 && obs_q.size() < exp_q.size(); c++) @(posedge clk);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); n_cmp++;
            if (obs_q.size() == 0) begin n_fail++; $display("FAIL abort_next_wb missing write want a=%0d", e.a); end
            else begin
                o = obs_q.pop_front();
                if (o.a !== e.a || o.d !== e.d || o.last !== e.last || o.cyc != e.cyc) begin
                    n_fail++; $display("FAIL abort_next_wb got a=%0d done=%b cyc=%0d d=%h want a=%0d done=%b cyc=%0d d=%h", o.a, o.last, o.cyc, o.d, e.a, e.last, e.cyc, e.d);
                end
            end
        end
        @(posedge clk); #1;
        n_cmp++;
        if (rf[0] !== {LANES{32'd12}}) begin n_fail++; $display("FAIL abort_next_r0 got %h want 0000000c", rf[0][31:0]); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_mul();
        test_back_to_back();
        test_same_dst();
        test_reset_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
